// File: rtl/alu_seq.sv
// Execute-stage ALU: logic/arithmetic ops finish in one cycle, logical shifts
// iterate one bit per cycle behind a start/busy/done handshake.
module alu_seq #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned SHAMT_W = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        alu_control,
  input  logic [DATA_W-1:0] alu_in_0,
  input  logic [DATA_W-1:0] alu_in_1,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] alu_out,
  output logic              zero_flag,
  output logic              invalid_op
);

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SLL = 4'd3;
  localparam logic [3:0] OP_SRL = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0]  cnt_q, cnt_d;
  logic                left_q, left_d;
  logic [DATA_W-1:0]   out_q, out_d;
  logic                zero_q, zero_d;
  logic                inv_q, inv_d;
  logic                done_q, done_d;

  logic [SHAMT_W-1:0]  shamt;
  logic [DATA_W-1:0]   shifted;

  assign shamt   = alu_in_1[SHAMT_W-1:0];
  assign shifted = left_q ? (acc_q << 1) : (acc_q >> 1);

  // State and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      left_q  <= 1'b0;
      out_q   <= '0;
      zero_q  <= 1'b0;
      inv_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
      inv_q   <= inv_d;
      done_q  <= done_d;
    end
  end

  // Next-state and result selection
  always_comb begin
    logic [DATA_W-1:0] res;
    logic              res_inv;
    logic              complete;

    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    out_d    = out_q;
    zero_d   = zero_q;
    inv_d    = inv_q;
    done_d   = 1'b0;
    res      = '0;
    res_inv  = 1'b0;
    complete = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          complete = 1'b1;
          case (alu_control)
            OP_AND: res = alu_in_0 & alu_in_1;
            OP_OR:  res = alu_in_0 | alu_in_1;
            OP_ADD: res = alu_in_0 + alu_in_1;
            OP_SUB: res = alu_in_0 - alu_in_1;
            OP_SLT: res = ($signed(alu_in_0) < $signed(alu_in_1)) ? DATA_W'(1) : '0;
            OP_SLL, OP_SRL: begin
              if (shamt == '0) begin
                res = alu_in_0;
              end else begin
                complete = 1'b0;
                state_d  = SHIFT;
                acc_d    = alu_in_0;
                cnt_d    = shamt;
                left_d   = (alu_control == OP_SLL);
              end
            end
            default: begin
              res     = '0;
              res_inv = 1'b1;
            end
          endcase
          if (complete) begin
            out_d  = res;
            zero_d = (res == '0);
            inv_d  = res_inv;
            done_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        acc_d = shifted;
        cnt_d = cnt_q - SHAMT_W'(1);
        // Last step: publish the shifted value directly from the shifter
        if (cnt_q == SHAMT_W'(1)) begin
          out_d   = shifted;
          zero_d  = (shifted == '0);
          inv_d   = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q == SHIFT);
  assign done       = done_q;
  assign alu_out    = out_q;
  assign zero_flag  = zero_q;
  assign invalid_op = inv_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: stimulus queues expected completions, a
// negedge monitor checks every done pulse for value, flags and cycle.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  alu_control;
  logic [63:0] alu_in_0;
  logic [63:0] alu_in_1;
  logic        busy;
  logic        done;
  logic [63:0] alu_out;
  logic        zero_flag;
  logic        invalid_op;

  typedef struct {
    logic [63:0] out;
    logic        inv;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  alu_seq #(.DATA_W(64)) dut (
    .clk(clk), .rst(rst), .start(start), .alu_control(alu_control),
    .alu_in_0(alu_in_0), .alu_in_1(alu_in_1), .busy(busy), .done(done),
    .alu_out(alu_out), .zero_flag(zero_flag), .invalid_op(invalid_op)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected completion
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 with alu_out 0x%h expected no completion (cycle %0d)", alu_out, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("alu_out", alu_out, e.out);
        chk("zero_flag", 64'(zero_flag), 64'(e.out == 64'd0));
        chk("invalid_op", 64'(invalid_op), 64'(e.inv));
        chk("done_cycle", 64'(cyc), 64'(e.due));
        chk("busy_with_done", 64'(busy), 64'd0);
      end
    end
  end

  // Present one operation for one edge; lat is the number of extra shift edges
  task automatic drive(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input logic inv, input int lat);
    exp_t e;
    alu_control = op;
    alu_in_0    = a;
    alu_in_1    = b;
    e.out = exp;
    e.inv = inv;
    e.due = cyc + 1 + lat;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic single(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input logic inv, input int lat);
    start = 1'b1;
    drive(op, a, b, exp, inv, lat);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d pending completions expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; alu_control = 4'd0; alu_in_0 = '0; alu_in_1 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_out", alu_out, 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);

    // Single-cycle sweep
    single(4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 0);
    single(4'd6, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 0);
    single(4'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 1'b0, 0);
    single(4'd0, 64'hF0, 64'h3C, 64'h30, 1'b0, 0);
    single(4'd1, 64'hF0, 64'h0F, 64'hFF, 1'b0, 0);
    wait_idle();

    // Reset mid-shift discards the operation
    start = 1'b1; alu_control = 4'd3; alu_in_0 = 64'd1; alu_in_1 = 64'd40;
    @(posedge clk); #1;
    start = 1'b0;
    chk("shift_busy", 64'(busy), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midreset_out", alu_out, 64'd0);
    chk("midreset_zero", 64'(zero_flag), 64'd0);
    chk("midreset_inv", 64'(invalid_op), 64'd0);
    chk("midreset_busy", 64'(busy), 64'd0);
    repeat (50) @(posedge clk);
    #1;

    // Shifts
    single(4'd3, 64'd1, 64'd63, 64'h8000_0000_0000_0000, 1'b0, 63);
    chk("sll63_busy", 64'(busy), 64'd1);
    wait_idle();
    single(4'd4, 64'h8000_0000_0000_0000, 64'd4, 64'h0800_0000_0000_0000, 1'b0, 4);
    wait_idle();
    single(4'd3, 64'h1234_5678_9ABC_DEF0, 64'd0, 64'h1234_5678_9ABC_DEF0, 1'b0, 0);
    single(4'd4, 64'hDEAD_BEEF_0000_0001, 64'd64, 64'hDEAD_BEEF_0000_0001, 1'b0, 0);
    wait_idle();

    // Start while busy is ignored
    single(4'd3, 64'd3, 64'd10, 64'h0000_0000_0000_0C00, 1'b0, 10);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; alu_control = 4'd2; alu_in_0 = 64'd1; alu_in_1 = 64'd1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();

    // Back-to-back, then SLT accepted in the final done cycle
    start = 1'b1;
    drive(4'd2, 64'd1, 64'd1, 64'd2, 1'b0, 0);
    drive(4'd2, 64'd2, 64'd2, 64'd4, 1'b0, 0);
    drive(4'd2, 64'd3, 64'd3, 64'd6, 1'b0, 0);
    drive(4'd7, 64'd5, 64'd3, 64'd0, 1'b0, 0);
    start = 1'b0;
    wait_idle();

    // Invalid code, then a valid op clears invalid_op
    single(4'd9, 64'hFF, 64'hFF, 64'd0, 1'b1, 0);
    single(4'd1, 64'h0A, 64'h50, 64'h5A, 1'b0, 0);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Sequential execute-stage ALU that sits directly downstream of the ALU control decoder and consumes its 4-bit operation code. Logic and arithmetic operations (AND, OR, ADD, SUB, SLT) complete in one cycle. Logical shifts (SLL, SRL) are performed iteratively, one bit position per cycle, which trades latency for area. A start/busy/done handshake lets the multicycle control FSM stall while a shift is in progress.

## Interface
Parameters:
- DATA_W, 64, operand and result width; must be a power of two, ≥ 8
- SHAMT_W, $clog2(DATA_W), width of the shift amount taken from alu_in_1

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request to execute; accepted only when busy = 0
- alu_control  input  4  operation code: 0 AND, 1 OR, 2 ADD, 3 SLL, 4 SRL, 6 SUB, 7 SLT; all other values are invalid
- alu_in_0  input  DATA_W  operand A; the shift source for SLL/SRL
- alu_in_1  input  DATA_W  operand B; bits [SHAMT_W-1:0] are the shift amount
- busy  output  1  high while an iterative shift is in progress
- done  output  1  one-cycle pulse; alu_out, zero_flag and invalid_op are valid in that cycle
- alu_out  output  DATA_W  registered result; holds until the next completion
- zero_flag  output  1  registered, (alu_out == 0)
- invalid_op  output  1  registered; set with done when the accepted code was invalid

## Operation
- States: IDLE and SHIFT. busy = (state == SHIFT).
- Accept rule: the operation is accepted when start = 1 and busy = 0 at a rising edge. At that edge alu_control, alu_in_0 and shamt = alu_in_1[SHAMT_W-1:0] are latched.
- Single-cycle path. It applies to AND, OR, ADD, SUB and SLT, to SLL/SRL with shamt = 0, and to invalid codes.
  - At the accept edge: alu_out ← result, done ← 1, state stays IDLE.
  - ADD and SUB are modulo 2^DATA_W; no carry or overflow is reported.
  - SLT is a signed two's-complement compare; the result is 1 or 0, zero-extended.
  - An invalid code gives alu_out ← 0, zero_flag ← 1, invalid_op ← 1.
- Shift path (SLL/SRL with shamt ≥ 1):
  - Accept edge: acc ← alu_in_0, cnt ← shamt, state ← SHIFT, done stays 0.
  - Each edge in SHIFT: acc shifts one position with zero fill (left for SLL, right for SRL), and cnt ← cnt − 1.
  - On the edge where cnt goes 1 → 0: alu_out ← shifted acc, done ← 1, state ← IDLE.
  - SRL is logical only; the MSB fills with 0.
- start while busy = 1 is ignored and not queued. Operand changes during SHIFT have no effect.
- invalid_op and zero_flag update only on completion edges, together with alu_out.
- Back-to-back: start may be high in the cycle done = 1, because busy is already 0. That start is accepted, so successive single-cycle operations give done high on consecutive cycles.
- Reset (rst = 1 at an edge, which overrides everything, including mid-shift): state ← IDLE, busy = 0, done = 0, alu_out = 0, zero_flag = 0, invalid_op = 0, acc = 0, cnt = 0. An in-flight shift is discarded and no done is produced for it.

## Timing
- Single-cycle operation: start accepted at edge N gives done = 1 and a valid alu_out during cycle N+1 (one edge of latency).
- Shift: latency is shamt edges. busy is high from edge N to edge N+shamt; done is high for one cycle after edge N+shamt.
- Maximum latency is DATA_W−1 edges (63 at the default width).
- done is never high for two consecutive cycles unless a new start was accepted.
- busy and done are never both high.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset: drive rst for 2 cycles mid-SLL with shamt = 40, then release. Required: outputs all 0, busy = 0, and no done pulse follows.
- Single-cycle sweep. Required done after 1 edge in every case:
  - ADD 0xFFFF_FFFF_FFFF_FFFF + 1 → alu_out 0, zero_flag = 1.
  - SUB 5 − 7 → 0xFFFF_FFFF_FFFF_FFFE.
  - SLT −1 < 1 → 1.
  - AND 0xF0 & 0x3C → 0x30.
  - OR 0xF0 | 0x0F → 0xFF.
- Shifts:
  - SLL 0x1 by 63 → 0x8000_0000_0000_0000, busy for 63 cycles, done at edge 63.
  - SRL 0x8000_0000_0000_0000 by 4 → 0x0800_0000_0000_0000 at edge 4.
  - SLL by 0 → unchanged operand, done after 1 edge.
  - SRL by 64 (only the low 6 bits are used) → shamt 0, operand unchanged.
- Busy rejection: during an SLL by 10, pulse start with ADD 1 + 1. Required: ignored, exactly one done, alu_out equals the shift result.
- Back-to-back: hold start high for three ADDs (1+1, 2+2, 3+3). Required: done high on 3 consecutive cycles with alu_out 2, 4, 6. Then start an SLT in the final done cycle; required: accepted.
- Invalid code: alu_control = 4'd9 → done after 1 edge, invalid_op = 1, alu_out = 0. The next valid operation clears invalid_op.
